// File: rtl/ddr_calib_watchdog_if.sv
// Signal bundle between the upstream DDR reset generator, the MIG and the
// calibration watchdog. The slave modport is the watchdog's view.
interface ddr_calib_watchdog_if #(
    parameter int RETRY_WIDTH = 2
) ();
    logic                   ddr_rst_n_i;
    logic                   init_calib_complete_i;
    logic                   mig_rst_n_o;
    logic                   calib_ok_o;
    logic                   calib_fail_o;
    logic                   calib_lost_o;
    logic [RETRY_WIDTH-1:0] retry_count_o;
    logic [2:0]             state_o;

    modport slave (
        input  ddr_rst_n_i,
        input  init_calib_complete_i,
        output mig_rst_n_o,
        output calib_ok_o,
        output calib_fail_o,
        output calib_lost_o,
        output retry_count_o,
        output state_o
    );

    modport master (
        output ddr_rst_n_i,
        output init_calib_complete_i,
        input  mig_rst_n_o,
        input  calib_ok_o,
        input  calib_fail_o,
        input  calib_lost_o,
        input  retry_count_o,
        input  state_o
    );
endinterface

// File: rtl/ddr_calib_watchdog.sv
// MIG calibration watchdog: forwards the upstream DDR reset, times calibration and
// forces bounded reset retries. Retries are enabled by defining DDR_WDOG_RETRY_EN.
module ddr_calib_watchdog #(
    parameter int TIMEOUT_CYCLES = 40000000,
    parameter int TIMEOUT_WIDTH  = 26,
    parameter int HOLD_CYCLES    = 9181,
    parameter int HOLD_WIDTH     = 15,
    parameter int MAX_RETRIES    = 3,
    parameter int RETRY_WIDTH    = 2
) (
    input  logic                clk_200,
    input  logic                sys_rst_i,
    ddr_calib_watchdog_if.slave wd
);
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_CAL  = 3'd1,
        CAL_DONE  = 3'd2,
        FORCE_RST = 3'd3,
        FAIL      = 3'd4
    } state_t;

    localparam logic [TIMEOUT_WIDTH-1:0] TMO_LAST  = TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);
    localparam logic [HOLD_WIDTH-1:0]    HOLD_LAST = HOLD_WIDTH'(HOLD_CYCLES - 1);
    localparam logic [RETRY_WIDTH-1:0]   RETRY_MAX = RETRY_WIDTH'(MAX_RETRIES);

    state_t                   state_q, state_d;
    logic                     cal_meta_q, cal_meta_d;
    logic                     cal_s_q, cal_s_d;
    logic [TIMEOUT_WIDTH-1:0] tmo_q, tmo_d;
    logic [HOLD_WIDTH-1:0]    hold_q, hold_d;
    logic [RETRY_WIDTH-1:0]   retry_q, retry_d;
    logic                     lost_q, lost_d;
    logic                     fail_q, fail_d;
    logic                     ok_q, ok_d;
    logic                     mig_rst_n_q, mig_rst_n_d;
    logic                     escalate;
    logic                     retry_ok;

`ifdef DDR_WDOG_RETRY_EN
    localparam bit RETRY_EN = 1'b1;
    assign wd.retry_count_o = retry_q;
`else
    localparam bit RETRY_EN = 1'b0;
    assign wd.retry_count_o = '0;
`endif

    assign retry_ok = RETRY_EN && (retry_q < RETRY_MAX);

    always_comb begin
        state_d    = state_q;
        lost_d     = lost_q;
        retry_d    = retry_q;
        escalate   = 1'b0;
        cal_meta_d = wd.init_calib_complete_i;
        cal_s_d    = cal_meta_q;

        // Upstream reset takes priority over every supervised state; FAIL ignores it.
        case (state_q)
            IDLE: begin
                if (wd.ddr_rst_n_i) state_d = WAIT_CAL;
            end
            WAIT_CAL: begin
                if (!wd.ddr_rst_n_i)      state_d = IDLE;
                else if (cal_s_q)         state_d = CAL_DONE;
                else if (tmo_q == TMO_LAST) escalate = 1'b1;
            end
            CAL_DONE: begin
                if (!wd.ddr_rst_n_i) begin
                    state_d = IDLE;
                end else if (!cal_s_q) begin
                    lost_d   = 1'b1;
                    escalate = 1'b1;
                end
            end
            FORCE_RST: begin
                if (!wd.ddr_rst_n_i)   state_d = IDLE;
                else if (hold_q == '0) state_d = WAIT_CAL;
            end
            FAIL: begin
                state_d = FAIL;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (escalate) begin
            if (retry_ok) begin
                retry_d = retry_q + RETRY_WIDTH'(1);
                state_d = FORCE_RST;
            end else begin
                state_d = FAIL;
            end
        end

        tmo_d = ((state_q == WAIT_CAL) && (state_d == WAIT_CAL)) ? tmo_q + TIMEOUT_WIDTH'(1) : '0;

        if (state_d == FORCE_RST)
            hold_d = (state_q == FORCE_RST) ? hold_q - HOLD_WIDTH'(1) : HOLD_LAST;
        else
            hold_d = '0;

        mig_rst_n_d = wd.ddr_rst_n_i && (state_d != FORCE_RST) && (state_d != FAIL);
        ok_d        = (state_d == CAL_DONE);
        fail_d      = fail_q || (state_d == FAIL);
    end

    always_ff @(posedge clk_200) begin
        if (sys_rst_i) begin
            state_q     <= IDLE;
            cal_meta_q  <= 1'b0;
            cal_s_q     <= 1'b0;
            tmo_q       <= '0;
            hold_q      <= '0;
            retry_q     <= '0;
            lost_q      <= 1'b0;
            fail_q      <= 1'b0;
            ok_q        <= 1'b0;
            mig_rst_n_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cal_meta_q  <= cal_meta_d;
            cal_s_q     <= cal_s_d;
            tmo_q       <= tmo_d;
            hold_q      <= hold_d;
            retry_q     <= retry_d;
            lost_q      <= lost_d;
            fail_q      <= fail_d;
            ok_q        <= ok_d;
            mig_rst_n_q <= mig_rst_n_d;
        end
    end

    assign wd.mig_rst_n_o  = mig_rst_n_q;
    assign wd.calib_ok_o   = ok_q;
    assign wd.calib_fail_o = fail_q;
    assign wd.calib_lost_o = lost_q;
    assign wd.state_o      = state_q;
endmodule

// File: tb/tb_ddr_calib_watchdog.sv
// Directed bench for ddr_calib_watchdog with TIMEOUT=100, HOLD=10, MAX_RETRIES=2.
// Follows the DDR_WDOG_RETRY_EN setting of the build.
module tb_ddr_calib_watchdog;
    logic clk_200 = 1'b0;
    logic sys_rst_i;
    int   checks = 0;
    int   errors = 0;

    ddr_calib_watchdog_if #(.RETRY_WIDTH(2)) wd_if ();

    ddr_calib_watchdog #(
        .TIMEOUT_CYCLES(100),
        .TIMEOUT_WIDTH (7),
        .HOLD_CYCLES   (10),
        .HOLD_WIDTH    (4),
        .MAX_RETRIES   (2),
        .RETRY_WIDTH   (2)
    ) dut (
        .clk_200  (clk_200),
        .sys_rst_i(sys_rst_i),
        .wd       (wd_if)
    );

    always #5 clk_200 = ~clk_200;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end else begin
            $display("ok   %s = %0d", tag, got);
        end
    endtask

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge clk_200);
        #1;
    endtask

    task automatic pulse_sys_rst();
        sys_rst_i = 1'b1;
        tick(1);
        sys_rst_i = 1'b0;
    endtask

    initial begin
        sys_rst_i                   = 1'b1;
        wd_if.ddr_rst_n_i           = 1'b0;
        wd_if.init_calib_complete_i = 1'b0;
        tick(3);
        chk("rst_state", wd_if.state_o, 0);
        chk("rst_mig", wd_if.mig_rst_n_o, 0);
        chk("rst_ok", wd_if.calib_ok_o, 0);
        chk("rst_fail", wd_if.calib_fail_o, 0);
        chk("rst_lost", wd_if.calib_lost_o, 0);
        chk("rst_retry", wd_if.retry_count_o, 0);

        sys_rst_i = 1'b0;
        tick(2);
        chk("idle_hold_state", wd_if.state_o, 0);
        chk("idle_hold_mig", wd_if.mig_rst_n_o, 0);

        // Nominal bring-up
        wd_if.ddr_rst_n_i = 1'b1;
        tick(1);
        chk("nom_mig_1cyc", wd_if.mig_rst_n_o, 1);
        chk("nom_wait_state", wd_if.state_o, 1);
        tick(49);
        wd_if.init_calib_complete_i = 1'b1;
        tick(2);
        chk("nom_ok_2cyc", wd_if.calib_ok_o, 0);
        tick(1);
        chk("nom_ok_3cyc", wd_if.calib_ok_o, 1);
        chk("nom_done_state", wd_if.state_o, 2);
        chk("nom_retry", wd_if.retry_count_o, 0);

        // Calibration loss
        wd_if.init_calib_complete_i = 1'b0;
        tick(2);
        chk("loss_still_done", wd_if.state_o, 2);
        tick(1);
`ifdef DDR_WDOG_RETRY_EN
        chk("loss_state", wd_if.state_o, 3);
        chk("loss_lost", wd_if.calib_lost_o, 1);
        chk("loss_retry", wd_if.retry_count_o, 1);
        chk("loss_mig", wd_if.mig_rst_n_o, 0);
        chk("loss_ok", wd_if.calib_ok_o, 0);
        tick(9);
        chk("pulse_9_mig", wd_if.mig_rst_n_o, 0);
        chk("pulse_9_state", wd_if.state_o, 3);
        tick(1);
        chk("pulse_10_mig", wd_if.mig_rst_n_o, 1);
        chk("pulse_10_state", wd_if.state_o, 1);

        // Tie-break: cal_s reaches 1 exactly on the timeout cycle
        tick(97);
        wd_if.init_calib_complete_i = 1'b1;
        tick(2);
        chk("tie_wait_state", wd_if.state_o, 1);
        tick(1);
        chk("tie_done_state", wd_if.state_o, 2);
        chk("tie_retry", wd_if.retry_count_o, 1);

        // Upstream reset in the middle of a forced pulse
        wd_if.init_calib_complete_i = 1'b0;
        tick(3);
        chk("up_force_state", wd_if.state_o, 3);
        chk("up_force_retry", wd_if.retry_count_o, 2);
        tick(4);
        wd_if.ddr_rst_n_i = 1'b0;
        tick(1);
        chk("up_idle_state", wd_if.state_o, 0);
        chk("up_idle_mig", wd_if.mig_rst_n_o, 0);
        chk("up_idle_retry", wd_if.retry_count_o, 2);
        chk("up_idle_lost", wd_if.calib_lost_o, 1);
        wd_if.ddr_rst_n_i = 1'b1;
        tick(1);
        chk("up_rel_state", wd_if.state_o, 1);
        chk("up_rel_mig", wd_if.mig_rst_n_o, 1);
        tick(99);
        chk("up_tmo_99", wd_if.state_o, 1);
        tick(1);
        chk("up_tmo_fail_state", wd_if.state_o, 4);
        chk("up_tmo_fail_flag", wd_if.calib_fail_o, 1);
        chk("up_tmo_fail_mig", wd_if.mig_rst_n_o, 0);

        // FAIL ignores the upstream reset
        wd_if.ddr_rst_n_i = 1'b0;
        tick(3);
        chk("fail_ddr_lo_state", wd_if.state_o, 4);
        wd_if.ddr_rst_n_i = 1'b1;
        tick(2);
        chk("fail_ddr_hi_state", wd_if.state_o, 4);
        chk("fail_ddr_hi_mig", wd_if.mig_rst_n_o, 0);

        pulse_sys_rst();
        chk("clr_state", wd_if.state_o, 0);
        chk("clr_fail", wd_if.calib_fail_o, 0);
        chk("clr_lost", wd_if.calib_lost_o, 0);
        chk("clr_retry", wd_if.retry_count_o, 0);
        chk("clr_mig", wd_if.mig_rst_n_o, 0);

        // Exhaustion: two forced pulses then FAIL
        tick(1);
        chk("ex_wait_state", wd_if.state_o, 1);
        tick(100);
        chk("ex_p1_state", wd_if.state_o, 3);
        chk("ex_p1_retry", wd_if.retry_count_o, 1);
        tick(10);
        chk("ex_w2_state", wd_if.state_o, 1);
        tick(100);
        chk("ex_p2_state", wd_if.state_o, 3);
        chk("ex_p2_retry", wd_if.retry_count_o, 2);
        tick(10);
        tick(100);
        chk("ex_fail_state", wd_if.state_o, 4);
        chk("ex_fail_flag", wd_if.calib_fail_o, 1);
        chk("ex_fail_mig", wd_if.mig_rst_n_o, 0);
        chk("ex_fail_lost", wd_if.calib_lost_o, 0);

        // Single retry, calibration arrives during the second window
        pulse_sys_rst();
        tick(1);
        tick(100);
        chk("sr_force_retry", wd_if.retry_count_o, 1);
        tick(10);
        chk("sr_w2_mig", wd_if.mig_rst_n_o, 1);
        tick(20);
        wd_if.init_calib_complete_i = 1'b1;
        tick(3);
        chk("sr_ok", wd_if.calib_ok_o, 1);
        chk("sr_state", wd_if.state_o, 2);
        chk("sr_retry", wd_if.retry_count_o, 1);
`else
        chk("nr_loss_state", wd_if.state_o, 4);
        chk("nr_loss_lost", wd_if.calib_lost_o, 1);
        chk("nr_loss_fail", wd_if.calib_fail_o, 1);
        chk("nr_loss_retry", wd_if.retry_count_o, 0);
        chk("nr_loss_mig", wd_if.mig_rst_n_o, 0);

        pulse_sys_rst();
        chk("nr_clr_fail", wd_if.calib_fail_o, 0);
        chk("nr_clr_lost", wd_if.calib_lost_o, 0);
        tick(1);
        chk("nr_wait_state", wd_if.state_o, 1);
        tick(99);
        chk("nr_tmo_99", wd_if.state_o, 1);
        tick(1);
        chk("nr_tmo_state", wd_if.state_o, 4);
        chk("nr_tmo_fail", wd_if.calib_fail_o, 1);
        chk("nr_tmo_retry", wd_if.retry_count_o, 0);
        chk("nr_tmo_lost", wd_if.calib_lost_o, 0);
        chk("nr_tmo_mig", wd_if.mig_rst_n_o, 0);

        pulse_sys_rst();
        tick(11);
        wd_if.ddr_rst_n_i = 1'b0;
        tick(1);
        chk("nr_up_state", wd_if.state_o, 0);
        chk("nr_up_mig", wd_if.mig_rst_n_o, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ddr_calib_watchdog.md
# ddr_calib_watchdog

Supervises PL MIG calibration downstream of the MMCM-lock-gated DDR reset generator. It takes that generator's active-low MIG reset, forwards it to the MIG `sys_rst`, and times `init_calib_complete` after each release. On timeout or loss of calibration it forces a fresh reset pulse into the MIG, up to a bounded retry count, before flagging permanent failure.

## Interface
- `TIMEOUT_CYCLES`, default 40000000: clk_200 cycles allowed from reset release to calibration complete (200 ms).
- `TIMEOUT_WIDTH`, default 26: timeout counter width; must hold `TIMEOUT_CYCLES-1`.
- `HOLD_CYCLES`, default 9181: length of a forced reset pulse, in cycles.
- `HOLD_WIDTH`, default 15: hold counter width.
- `MAX_RETRIES`, default 3: forced resets allowed before FAIL.
- `RETRY_WIDTH`, default 2: retry counter width; must hold `MAX_RETRIES`.
- `clk_200`, in, 1: sole clock, 200 MHz.
- `sys_rst_i`, in, 1: one clock; reset is synchronous and active-high.
- `ddr_rst_n_i`, in, 1: active-low MIG reset from the upstream lock-gated reset generator (clk_200 domain).
- `init_calib_complete_i`, in, 1: MIG calibration done, from the ui_clk domain (asynchronous).
- `mig_rst_n_o`, out, 1: active-low reset to MIG `sys_rst`, registered.
- `calib_ok_o`, out, 1: calibration currently complete and supervised.
- `calib_fail_o`, out, 1: sticky; retries exhausted.
- `calib_lost_o`, out, 1: sticky; calibration dropped after being reached.
- `retry_count_o`, out, RETRY_WIDTH: number of forced resets issued.
- `state_o`, out, 3: FSM state, for debug.

## Operation
- `init_calib_complete_i` passes through a 2-flop synchronizer, giving `cal_s`.
- States, with `state_o` encoding: IDLE=0, WAIT_CAL=1, CAL_DONE=2, FORCE_RST=3, FAIL=4.
- **IDLE**
  - Timeout counter held at 0.
  - Go to WAIT_CAL when `ddr_rst_n_i`=1.
- **WAIT_CAL**
  - Timeout counter starts at 0 on entry and increments each cycle.
  - `cal_s`=1: go to CAL_DONE.
  - Counter = `TIMEOUT_CYCLES-1` and `cal_s`=0:
    - If `retry_count < MAX_RETRIES`: increment retry count, go to FORCE_RST.
    - Otherwise: go to FAIL.
  - If `cal_s`=1 on the timeout cycle, CAL_DONE wins and no retry is counted.
- **CAL_DONE**
  - `calib_ok_o`=1.
  - `cal_s`=0: set `calib_lost_o`, then apply the same retry-or-FAIL rule as a timeout.
- **FORCE_RST**
  - Hold counter loaded with `HOLD_CYCLES-1` on entry, decremented each cycle.
  - At 0: go to WAIT_CAL.
- **FAIL**
  - `calib_fail_o`=1.
  - Left only via `sys_rst_i`.
- **Upstream reset:** `ddr_rst_n_i`=0 in WAIT_CAL, CAL_DONE or FORCE_RST sends the FSM to IDLE next cycle.
  - Counters cleared.
  - Retry count and sticky flags kept.
  - FAIL ignores `ddr_rst_n_i`.
- **Next-state value of `mig_rst_n_o`:** `ddr_rst_n_i` AND (next state ∉ {FORCE_RST, FAIL}).
  - FAIL holds the MIG in reset.
- **`sys_rst_i`:** all state cleared, including retry count, sticky flags and synchronizer.

## Timing
- **Reset values:**
  - `mig_rst_n_o`=0; `calib_ok_o`=0; `calib_fail_o`=0; `calib_lost_o`=0.
  - `retry_count_o`=0; `state_o`=0.
- **`ddr_rst_n_i` rise to `mig_rst_n_o` rise:** 1 cycle.
- **`init_calib_complete_i` rise to `calib_ok_o` rise:** 3 cycles (2 sync + 1 FSM).
- **Timeout:** FORCE_RST is entered exactly `TIMEOUT_CYCLES` cycles after WAIT_CAL entry.
- **Forced pulse:** `mig_rst_n_o` is low for exactly `HOLD_CYCLES` cycles.
- **Sticky flags:** `calib_lost_o` and `calib_fail_o` assert in the same cycle as the state transition that causes them.

## Configuration
- `DDR_WDOG_RETRY_EN`, defined: retry behaviour as above.
- `DDR_WDOG_RETRY_EN`, undefined:
  - Timeout or calibration loss goes straight to FAIL.
  - FORCE_RST is unreachable.
  - `retry_count_o` is tied to 0.

## Test plan
All scenarios use `TIMEOUT_CYCLES`=100, `HOLD_CYCLES`=10, `MAX_RETRIES`=2 and `DDR_WDOG_RETRY_EN` defined unless stated.
- **Nominal:** release `ddr_rst_n_i`, raise calib 50 cycles later.
  - `mig_rst_n_o`=1 after 1 cycle.
  - `calib_ok_o`=1 3 cycles after calib rises.
  - `retry_count_o`=0.
- **Single retry:** calib never rises.
  - After 100 cycles, `mig_rst_n_o` is low for exactly 10 cycles and `retry_count_o`=1.
  - Raise calib during the second window: `calib_ok_o`=1.
- **Exhaustion:** calib never rises.
  - Two forced pulses, then FAIL: `calib_fail_o`=1, `mig_rst_n_o`=0.
  - Toggling `ddr_rst_n_i` has no effect.
  - `sys_rst_i` clears all outputs.
- **Loss and tie-break:**
  - Drop calib in CAL_DONE: `calib_lost_o`=1, then a forced pulse.
  - Calib synced on the timeout cycle: CAL_DONE, no retry counted.
- **Upstream reset:** drop `ddr_rst_n_i` mid-FORCE_RST.
  - IDLE next cycle; `mig_rst_n_o`=0.
  - Retry count kept.
  - On release the timeout restarts from 0.
- **Macro undefined:** first timeout enters FAIL directly; `retry_count_o` stays 0.
